mrr_iq_replay_buffer: RTL and testbench

Circular IQ sample store that serves the replay side of the MRR gateway receive chain. It taps the live IQ stream feeding `mrr_cfo_fft_interpreter` and answers that block's `iq_sync_req` and `iq_flush_req` handshakes. On request it streams stored samples back through the `i_replay_*` interface, so the header search can re-run correlation over samples already seen. It never backpressures the live stream: oldest samples are overwritten, and a lapped replay drops its oldest sample.

---
 rtl/mrr_iq_replay_buffer.sv | 145 ++++++++++++++
 tb/tb_mrr_iq_replay_buffer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mrr_iq_replay_buffer.sv
// Circular IQ sample store for the MRR receive chain: taps the live stream, never stalls it,
// and replays retained samples on sync requests so the header search can re-correlate.
module mrr_iq_replay_buffer #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata_i,
    input  logic [DATA_WIDTH-1:0] s_tdata_q,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] o_replay_tdata_i,
    output logic [DATA_WIDTH-1:0] o_replay_tdata_q,
    output logic                  o_replay_tlast,
    output logic                  o_replay_tvalid,
    input  logic                  o_replay_tready,
    output logic                  o_replay_empty,
    input  logic                  iq_sync_req,
    input  logic                  iq_sync_latest,
    output logic                  iq_sync_ack,
    input  logic                  iq_flush_req,
    output logic                  iq_flush_done,
    output logic [ADDR_WIDTH:0]   o_fill,
    output logic [15:0]           o_overrun_count
);

    localparam int WORD_W = 2 * DATA_WIDTH + 1;
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_M1 = DEPTH_C - (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {IDLE, REPLAY, FLUSH} state_e;

    logic [WORD_W-1:0]     mem_q [DEPTH];
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [ADDR_WIDTH:0]   dist_q, dist_d, fill_q, fill_d, fillWr;
    logic                  syncArmed_q, syncArmed_d, flushArmed_q, flushArmed_d;
    logic                  tvalid_q, tvalid_d, empty_q, empty_d;
    logic                  ack_q, done_q;
    logic [WORD_W-1:0]     outWord_q;
    logic [15:0]           ovr_q, ovr_d;
    logic                  flushSvc, syncSvc, readIssue, overrun;

    assign s_tready = 1'b1;

    always_ff @(posedge clk) begin
        if (s_tvalid) mem_q[wp_q] <= {s_tlast, s_tdata_q, s_tdata_i};
    end

    // Flush outranks sync; a sync seen during flush waits until IDLE.
    assign flushSvc  = iq_flush_req && flushArmed_q;
    assign syncSvc   = iq_sync_req && syncArmed_q && !flushSvc && (state_q != FLUSH);
    assign readIssue = (state_q == REPLAY) && (dist_q != '0) && (!tvalid_q || o_replay_tready)
                       && !flushSvc && !syncSvc;
    assign overrun   = (state_q == REPLAY) && s_tvalid && !readIssue && (dist_q >= DEPTH_M1)
                       && !flushSvc && !syncSvc;

    assign wp_d   = s_tvalid ? wp_q + ADDR_WIDTH'(1) : wp_q;
    assign fillWr = (s_tvalid && fill_q != DEPTH_C) ? fill_q + (ADDR_WIDTH + 1)'(1) : fill_q;

    always_comb begin
        state_d      = state_q;
        rp_d         = rp_q;
        dist_d       = dist_q;
        fill_d       = fillWr;
        syncArmed_d  = iq_sync_req ? (syncArmed_q && !syncSvc) : 1'b1;
        flushArmed_d = iq_flush_req ? (flushArmed_q && !flushSvc) : 1'b1;
        tvalid_d     = tvalid_q;
        ovr_d        = ovr_q;
        if (flushSvc) begin
            state_d = FLUSH;
            rp_d    = wp_d;
            dist_d  = '0;
            fill_d  = '0;
        end else if (syncSvc) begin
            state_d = REPLAY;
            if (iq_sync_latest) begin
                rp_d   = wp_d;
                dist_d = '0;
            end else begin
                // Using post-write pointers keeps a same-cycle write inside the replay window.
                rp_d   = wp_d - fillWr[ADDR_WIDTH-1:0];
                dist_d = fillWr;
            end
        end else begin
            if (state_q == FLUSH) state_d = IDLE;
            if (readIssue || overrun) rp_d = rp_q + ADDR_WIDTH'(1);
            if (state_q == REPLAY) begin
                if (s_tvalid && !overrun && !readIssue) dist_d = dist_q + (ADDR_WIDTH + 1)'(1);
                else if (readIssue && !s_tvalid)        dist_d = dist_q - (ADDR_WIDTH + 1)'(1);
            end
            if (overrun && ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;
        end
        if (flushSvc || syncSvc)              tvalid_d = 1'b0;
        else if (readIssue)                   tvalid_d = 1'b1;
        else if (tvalid_q && o_replay_tready) tvalid_d = 1'b0;
        empty_d = !tvalid_d && (dist_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wp_q         <= '0;
            rp_q         <= '0;
            dist_q       <= '0;
            fill_q       <= '0;
            syncArmed_q  <= 1'b1;
            flushArmed_q <= 1'b1;
            tvalid_q     <= 1'b0;
            empty_q      <= 1'b1;
            ack_q        <= 1'b0;
            done_q       <= 1'b0;
            outWord_q    <= '0;
            ovr_q        <= '0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            dist_q       <= dist_d;
            fill_q       <= fill_d;
            syncArmed_q  <= syncArmed_d;
            flushArmed_q <= flushArmed_d;
            tvalid_q     <= tvalid_d;
            empty_q      <= empty_d;
            ack_q        <= syncSvc;
            done_q       <= (state_q == FLUSH) && !flushSvc;
            ovr_q        <= ovr_d;
            if (readIssue) outWord_q <= mem_q[rp_q];
        end
    end

    assign o_replay_tdata_i = outWord_q[DATA_WIDTH-1:0];
    assign o_replay_tdata_q = outWord_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign o_replay_tlast   = outWord_q[WORD_W-1];
    assign o_replay_tvalid  = tvalid_q;
    assign o_replay_empty   = empty_q;
    assign iq_sync_ack      = ack_q;
    assign iq_flush_done    = done_q;
    assign o_fill           = fill_q;
    assign o_overrun_count  = ovr_q;

endmodule

// File: tb/tb_mrr_iq_replay_buffer.sv
// Scoreboard bench for mrr_iq_replay_buffer: stimulus pushes expected replay samples,
// a negedge monitor pops and compares whenever a replay beat is accepted.
module tb_mrr_iq_replay_buffer;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] sDataI, sDataQ;
    logic          sLast, sValid, sReady;
    logic [DW-1:0] rDataI, rDataQ;
    logic          rLast, rValid, rReady, rEmpty;
    logic          syncReq, syncLatest, syncAck, flushReq, flushDone;
    logic [AW:0]   fill;
    logic [15:0]   ovrCount;

    typedef struct {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        logic          last;
        int            cycle;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    mrr_iq_replay_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .s_tdata_i(sDataI), .s_tdata_q(sDataQ), .s_tlast(sLast), .s_tvalid(sValid),
        .s_tready(sReady),
        .o_replay_tdata_i(rDataI), .o_replay_tdata_q(rDataQ), .o_replay_tlast(rLast),
        .o_replay_tvalid(rValid), .o_replay_tready(rReady), .o_replay_empty(rEmpty),
        .iq_sync_req(syncReq), .iq_sync_latest(syncLatest), .iq_sync_ack(syncAck),
        .iq_flush_req(flushReq), .iq_flush_done(flushDone),
        .o_fill(fill), .o_overrun_count(ovrCount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sample value v maps to a fixed I/Q/tlast pattern so replayed words are self-identifying.
    function automatic exp_t model(input int v, input int c);
        exp_t e;
        e.i     = DW'(v);
        e.q     = DW'(v) ^ 16'h5A5A;
        e.last  = e.i[0];
        e.cycle = c;
        return e;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    // Drives one live sample during the current cycle.
    task automatic applyStimulus(input int v);
        exp_t e;
        e = model(v, -1);
        sDataI = e.i;
        sDataQ = e.q;
        sLast  = e.last;
        sValid = 1'b1;
        nextCycle();
        sValid = 1'b0;
    endtask

    task automatic pushExp(input int v, input int c);
        expQ.push_back(model(v, c));
    endtask

    task automatic doSync(input logic latest);
        syncLatest = latest;
        syncReq    = 1'b1;
        nextCycle();
        checkOutput("sync_ack", 64'(syncAck), 64'd1);
        syncReq = 1'b0;
    endtask

    task automatic doFlush();
        flushReq = 1'b1;
        nextCycle();
        checkOutput("flush_tvalid_low", 64'(rValid), 64'd0);
        checkOutput("flush_done_early", 64'(flushDone), 64'd0);
        checkOutput("flush_fill_zero", 64'(fill), 64'd0);
        nextCycle();
        checkOutput("flush_done", 64'(flushDone), 64'd1);
        flushReq = 1'b0;
        nextCycle();
        checkOutput("flush_done_pulse", 64'(flushDone), 64'd0);
    endtask

    // Monitor: every accepted replay beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && rValid && rReady) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL replay_unexpected at cycle %0d: got i=%0d expected no beat", cyc, rDataI);
            end else begin
                monE = expQ.pop_front();
                checkOutput("replay_data", 64'({rLast, rDataQ, rDataI}), 64'({monE.last, monE.q, monE.i}));
                if (monE.cycle >= 0) checkOutput("replay_cycle", 64'(cyc), 64'(monE.cycle));
            end
        end
    end

    initial begin
        int n, r, ackCnt;
        rst = 1'b1; sDataI = '0; sDataQ = '0; sLast = 1'b0; sValid = 1'b0; rReady = 1'b1;
        syncReq = 1'b0; syncLatest = 1'b0; flushReq = 1'b0;
        repeat (3) nextCycle();
        checkOutput("rst_tvalid", 64'(rValid), 64'd0);
        checkOutput("rst_empty", 64'(rEmpty), 64'd1);
        checkOutput("rst_tdata", 64'({rLast, rDataQ, rDataI}), 64'd0);
        checkOutput("rst_ack_done", 64'({syncAck, flushDone}), 64'd0);
        checkOutput("rst_fill", 64'(fill), 64'd0);
        checkOutput("rst_overrun", 64'(ovrCount), 64'd0);
        checkOutput("tready_const", 64'(sReady), 64'd1);
        rst = 1'b0;
        nextCycle();

        // Ten samples, then replay from oldest on consecutive cycles.
        for (int v = 1; v <= 10; v++) applyStimulus(v);
        n = cyc;
        doSync(1'b0);
        for (int v = 1; v <= 10; v++) pushExp(v, n + 2 + (v - 1));
        nextCycle();
        checkOutput("sync_ack_single", 64'(syncAck), 64'd0);
        repeat (10) nextCycle();
        checkOutput("t1_empty", 64'(rEmpty), 64'd1);
        checkOutput("t1_tvalid", 64'(rValid), 64'd0);

        // Fill saturation: 20 writes retain only the newest 16.
        doFlush();
        for (int v = 1; v <= 20; v++) applyStimulus(v);
        checkOutput("t2_fill_sat", 64'(fill), 64'd16);
        n = cyc;
        doSync(1'b0);
        for (int v = 5; v <= 20; v++) pushExp(v, n + 2 + (v - 5));
        repeat (17) nextCycle();
        checkOutput("t2_empty", 64'(rEmpty), 64'd1);
        checkOutput("t2_overrun", 64'(ovrCount), 64'd0);

        // Latest mode: only fresh writes, each valid two cycles after its write.
        doSync(1'b1);
        syncLatest = 1'b0;
        nextCycle();
        for (int k = 0; k < 3; k++) begin
            pushExp(100 + k, cyc + 2);
            applyStimulus(100 + k);
        end
        repeat (4) nextCycle();
        checkOutput("t3_empty", 64'(rEmpty), 64'd1);

        // Stall the consumer and lap the reader by five samples.
        rReady = 1'b0;
        pushExp(200, -1);
        applyStimulus(200);
        nextCycle();
        nextCycle();
        checkOutput("t4_hold_valid", 64'(rValid), 64'd1);
        checkOutput("t4_hold_data", 64'(rDataI), 64'd200);
        for (int v = 201; v <= 220; v++) applyStimulus(v);
        checkOutput("t4_overrun", 64'(ovrCount), 64'd5);
        checkOutput("t4_hold_valid2", 64'(rValid), 64'd1);
        checkOutput("t4_hold_data2", 64'({rLast, rDataQ, rDataI}),
                    64'({model(200, 0).last, model(200, 0).q, model(200, 0).i}));
        rReady = 1'b1;
        r = cyc;
        for (int v = 206; v <= 220; v++) pushExp(v, r + 1 + (v - 206));
        repeat (17) nextCycle();
        checkOutput("t4_empty", 64'(rEmpty), 64'd1);

        // Flush and sync together mid-replay: flush wins, sync serviced afterwards.
        n = cyc;
        doSync(1'b0);
        pushExp(205, n + 2);
        pushExp(206, n + 3);
        pushExp(207, n + 4);
        repeat (3) nextCycle();
        flushReq = 1'b1;
        syncReq  = 1'b1;
        nextCycle();
        checkOutput("t5_tvalid_low", 64'(rValid), 64'd0);
        checkOutput("t5_fill_zero", 64'(fill), 64'd0);
        checkOutput("t5_done_early", 64'(flushDone), 64'd0);
        checkOutput("t5_ack_early", 64'(syncAck), 64'd0);
        nextCycle();
        checkOutput("t5_done", 64'(flushDone), 64'd1);
        checkOutput("t5_ack_during_done", 64'(syncAck), 64'd0);
        flushReq = 1'b0;
        nextCycle();
        checkOutput("t5_ack_after_flush", 64'(syncAck), 64'd1);
        checkOutput("t5_done_pulse", 64'(flushDone), 64'd0);
        syncReq = 1'b0;
        repeat (2) nextCycle();
        checkOutput("t5_empty", 64'(rEmpty), 64'd1);
        checkOutput("t5_tvalid", 64'(rValid), 64'd0);

        // A held request is acknowledged once; re-arming needs a low level.
        ackCnt = 0;
        syncReq = 1'b1;
        repeat (5) begin
            nextCycle();
            if (syncAck) ackCnt++;
        end
        syncReq = 1'b0;
        nextCycle();
        if (syncAck) ackCnt++;
        checkOutput("t6_ack_count", 64'(ackCnt), 64'd1);
        doSync(1'b0);

        repeat (4) nextCycle();
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
